i2c_target: RTL and testbench

- I2C target (slave) peripheral. It responds to an external I2C controller on scl/sda with a 7-bit address match, write-pointer, multi-byte write and sequential read.
- It serves four 8-bit registers that the core can also read and write over the rib bus.
- Default address and reset contents emulate an LM75-style temperature sensor, so the bench can check it against the I2C controller peripheral.
- It also serves as a loopback target for SoC simulation.

---
 rtl/i2c_target_pkg.sv | 51 +++++
 rtl/i2c_target_sync_edge.sv | 55 +++++
 rtl/i2c_target.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: FSM states, rib offsets,
// register reset contents and bus-condition helpers.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    // rib byte offsets; bit 4 separates the register file from status
    localparam logic [4:0] RIB_REG0_OFS   = 5'h00;
    localparam logic [4:0] RIB_REG1_OFS   = 5'h04;
    localparam logic [4:0] RIB_REG2_OFS   = 5'h08;
    localparam logic [4:0] RIB_REG3_OFS   = 5'h0C;
    localparam logic [4:0] RIB_STATUS_OFS = 5'h10;
    localparam int         RIB_SEL_BIT    = 4;

    // LM75-style power-up contents (temperature 25.5 C style pattern)
    localparam logic [7:0] REG0_RST = 8'h19;
    localparam logic [7:0] REG1_RST = 8'h80;
    localparam logic [7:0] REG2_RST = 8'h00;
    localparam logic [7:0] REG3_RST = 8'h00;

    function automatic logic [7:0] reg_reset_value(input logic [1:0] idx);
        case (idx)
            2'd0:    return REG0_RST;
            2'd1:    return REG1_RST;
            2'd2:    return REG2_RST;
            default: return REG3_RST;
        endcase
    endfunction

    // START: sda falls while scl stays high
    function automatic logic is_start(input logic scl_prev, input logic scl_now,
                                      input logic sda_prev, input logic sda_now);
        return scl_prev & scl_now & sda_prev & ~sda_now;
    endfunction

    // STOP: sda rises while scl stays high
    function automatic logic is_stop(input logic scl_prev, input logic scl_now,
                                     input logic sda_prev, input logic sda_now);
        return scl_prev & scl_now & ~sda_prev & sda_now;
    endfunction

endpackage

// File: rtl/i2c_target_sync_edge.sv
// Synchronises scl and sda into clk and derives edge / bus-condition pulses.
module i2c_target_sync_edge
    import i2c_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_level,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // lane 0 = scl, lane 1 = sda
    logic [1:0] line_in;
    logic [1:0] line_level;
    logic [1:0] line_prev;

    assign line_in = {sda, scl};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] pipe_reg;
            logic                   hist_reg;

            // synchroniser chain plus one history flop; idle bus level is high
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_reg <= '1;
                    hist_reg <= 1'b1;
                end else begin
                    pipe_reg <= {pipe_reg[SYNC_STAGES-2:0], line_in[gi]};
                    hist_reg <= pipe_reg[SYNC_STAGES-1];
                end
            end

            assign line_level[gi] = pipe_reg[SYNC_STAGES-1];
            assign line_prev[gi]  = hist_reg;
        end
    endgenerate

    assign scl_level = line_level[0];
    assign sda_level = line_level[1];
    assign scl_rise  = line_level[0] & ~line_prev[0];
    assign scl_fall  = ~line_level[0] & line_prev[0];
    assign start_det = is_start(line_prev[0], line_level[0], line_prev[1], line_level[1]);
    assign stop_det  = is_stop(line_prev[0], line_level[0], line_prev[1], line_level[1]);

endmodule

// File: rtl/i2c_target.sv
// I2C target serving four 8-bit registers, also accessible over rib.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        scl,
    inout  wire         sda,
    output logic        busy_o,
    output logic        wr_done_o
);

    logic scl_level, sda_level, scl_rise, scl_fall, start_det, stop_det;

    state_t      state_reg;
    logic [3:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic        rw_reg;
    logic        first_byte_reg;
    logic        ack_drv_reg;
    logic        wrote_reg;
    logic        sda_oe_reg;
    logic        busy_reg;
    logic        wr_done_reg;
    logic [1:0]  ptr_reg;
    logic [7:0]  regs [4];

    logic [7:0]  byte_in;
    logic [1:0]  ptr_inc;
    logic        unused_ok;

    i2c_target_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .scl_level (scl_level),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in   = {shift_reg[6:0], sda_level};
    assign ptr_inc   = ptr_reg + 2'd1;
    assign sda       = sda_oe_reg ? 1'b0 : 1'bz;
    assign busy_o    = busy_reg;
    assign wr_done_o = wr_done_reg;
    assign unused_ok = &{1'b0, scl_level, addr_i[31:5], addr_i[1:0], data_i[31:8]};

    // protocol FSM plus register file; the rib write is applied last so it wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 8'h00;
            rw_reg         <= 1'b0;
            first_byte_reg <= 1'b0;
            ack_drv_reg    <= 1'b0;
            wrote_reg      <= 1'b0;
            sda_oe_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            wr_done_reg    <= 1'b0;
            ptr_reg        <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= reg_reset_value(i[1:0]);
            end
        end else begin
            wr_done_reg <= 1'b0;
            if (stop_det) begin
                state_reg   <= ST_IDLE;
                sda_oe_reg  <= 1'b0;
                busy_reg    <= 1'b0;
                ack_drv_reg <= 1'b0;
                wr_done_reg <= wrote_reg;
                wrote_reg   <= 1'b0;
            end else if (start_det) begin
                // repeated START keeps busy and the wrote flag until STOP
                state_reg   <= ST_ADDR;
                bit_cnt_reg <= 4'd0;
                sda_oe_reg  <= 1'b0;
                ack_drv_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= byte_in;
                            if (bit_cnt_reg == 4'd7) begin
                                bit_cnt_reg <= 4'd0;
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state_reg <= ST_ADDR_ACK;
                                    rw_reg    <= byte_in[0];
                                    busy_reg  <= 1'b1;
                                end else begin
                                    state_reg <= ST_IGNORE;
                                    busy_reg  <= 1'b0;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv_reg) begin
                                sda_oe_reg  <= 1'b1;
                                ack_drv_reg <= 1'b1;
                            end else begin
                                ack_drv_reg <= 1'b0;
                                if (!rw_reg) begin
                                    state_reg      <= ST_WR_BYTE;
                                    first_byte_reg <= 1'b1;
                                    sda_oe_reg     <= 1'b0;
                                    bit_cnt_reg    <= 4'd0;
                                end else begin
                                    // first read bit goes out on this same fall
                                    state_reg   <= ST_RD_BYTE;
                                    shift_reg   <= regs[ptr_reg];
                                    sda_oe_reg  <= ~regs[ptr_reg][7];
                                    bit_cnt_reg <= 4'd1;
                                end
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shift_reg <= byte_in;
                            if (bit_cnt_reg == 4'd7) begin
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= ST_WR_ACK;
                                if (first_byte_reg) begin
                                    ptr_reg        <= byte_in[1:0];
                                    first_byte_reg <= 1'b0;
                                end else begin
                                    regs[ptr_reg] <= byte_in;
                                    ptr_reg       <= ptr_inc;
                                    wrote_reg     <= 1'b1;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv_reg) begin
                                sda_oe_reg  <= 1'b1;
                                ack_drv_reg <= 1'b1;
                            end else begin
                                sda_oe_reg  <= 1'b0;
                                ack_drv_reg <= 1'b0;
                                state_reg   <= ST_WR_BYTE;
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        // bit_cnt counts bits already placed on the bus
                        if (scl_fall) begin
                            if (bit_cnt_reg == 4'd0) begin
                                sda_oe_reg  <= ~shift_reg[7];
                                bit_cnt_reg <= 4'd1;
                            end else if (bit_cnt_reg == 4'd8) begin
                                sda_oe_reg  <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= ST_RD_ACK;
                            end else begin
                                sda_oe_reg  <= ~shift_reg[6];
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_level) begin
                                ptr_reg     <= ptr_inc;
                                shift_reg   <= regs[ptr_inc];
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= ST_RD_BYTE;
                            end else begin
                                state_reg <= ST_IGNORE;
                            end
                        end
                    end
                    default: begin
                        sda_oe_reg <= 1'b0;
                    end
                endcase
            end
            if (we_i && !addr_i[RIB_SEL_BIT]) begin
                regs[addr_i[3:2]] <= data_i[7:0];
            end
        end
    end

    // combinational rib read mux
    always_comb begin
        data_o = 32'h0;
        if (addr_i[RIB_SEL_BIT]) begin
            data_o = {28'b0, busy_reg, 1'b0, ptr_reg};
        end else begin
            data_o = {24'b0, regs[addr_i[3:2]]};
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller and rib accesses checked
// against a transaction-level model of the register file and pointer.
module tb_i2c_target;

    localparam int Q = 6;   // clk cycles per quarter scl period

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic        busy_o;
    logic        wr_done_o;
    wire         sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .scl       (scl),
        .sda       (sda),
        .busy_o    (busy_o),
        .wr_done_o (wr_done_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int wr_done_cnt = 0;

    // count clk cycles with wr_done_o high (a proper pulse adds exactly 1)
    always @(negedge clk) if (wr_done_o) wr_done_cnt++;

    // reference model: register contents and pointer
    logic [7:0] m_regs [4];
    logic [1:0] m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_regs[0] = 8'h19; m_regs[1] = 8'h80; m_regs[2] = 8'h00; m_regs[3] = 8'h00;
        m_ptr = 2'd0;
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b0; wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; wait_q();
        scl = 1'b1;     wait_q(); wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic recv_bit(output logic b);
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        b = (sda !== 1'b0);
        wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack_n);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic rib_write(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        addr_i = a; data_i = {24'h0, d}; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic rib_read(input logic [31:0] a, output logic [31:0] d);
        addr_i = a;
        #1;
        d = data_o;
    endtask

    // compare all four registers and status against the model (bus idle)
    task automatic check_all(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            rib_read(i * 4, d);
            check_eq($sformatf("%s_reg%0d", tag, i), d, {24'h0, m_regs[i]});
        end
        rib_read(32'h10, d);
        check_eq($sformatf("%s_status", tag), d, {30'h0, m_ptr});
    endtask

    task automatic txn_write(input string tag, input logic [7:0] bq[$]);
        logic ack_n;
        int   done0 = wr_done_cnt;
        bus_start();
        write_byte(8'h90, ack_n);
        check_eq({tag, "_addr_ack"}, {31'h0, ack_n}, 32'h0);
        check_eq({tag, "_busy"}, {31'h0, busy_o}, 32'h1);
        foreach (bq[i]) begin
            write_byte(bq[i], ack_n);
            check_eq($sformatf("%s_ack%0d", tag, i), {31'h0, ack_n}, 32'h0);
        end
        bus_stop();
        wait_q();
        check_eq({tag, "_busy_end"}, {31'h0, busy_o}, 32'h0);
        if (bq.size() > 0) begin
            m_ptr = bq[0][1:0];
            for (int i = 1; i < bq.size(); i++) begin
                m_regs[m_ptr] = bq[i];
                m_ptr = m_ptr + 2'd1;
            end
        end
        check_eq({tag, "_wr_done"}, wr_done_cnt - done0, (bq.size() > 1) ? 1 : 0);
        $display("txn %s: write %0d bytes (incl. ptr), ptr now %0d", tag, bq.size(), m_ptr);
    endtask

    // reads n bytes, optionally after a pointer write and repeated START
    task automatic txn_read(input string tag, input int n, input logic set_ptr, input logic [7:0] ptr_b);
        logic       ack_n;
        logic [7:0] d;
        int         done0 = wr_done_cnt;
        bus_start();
        if (set_ptr) begin
            write_byte(8'h90, ack_n);
            check_eq({tag, "_waddr_ack"}, {31'h0, ack_n}, 32'h0);
            write_byte(ptr_b, ack_n);
            check_eq({tag, "_ptr_ack"}, {31'h0, ack_n}, 32'h0);
            m_ptr = ptr_b[1:0];
            bus_start();
            check_eq({tag, "_busy_rs"}, {31'h0, busy_o}, 32'h1);
        end
        write_byte(8'h91, ack_n);
        check_eq({tag, "_raddr_ack"}, {31'h0, ack_n}, 32'h0);
        for (int k = 0; k < n; k++) begin
            read_byte(d, k == n - 1);
            check_eq($sformatf("%s_rd%0d", tag, k), {24'h0, d}, {24'h0, m_regs[m_ptr]});
            if (k < n - 1) m_ptr = m_ptr + 2'd1;
        end
        bus_stop();
        wait_q();
        check_eq({tag, "_busy_end"}, {31'h0, busy_o}, 32'h0);
        check_eq({tag, "_no_wr_done"}, wr_done_cnt - done0, 0);
        $display("txn %s: read %0d bytes, ptr now %0d", tag, n, m_ptr);
    endtask

    task automatic txn_bad(input string tag, input logic [7:0] abyte, input int nextra);
        logic ack_n;
        int   done0 = wr_done_cnt;
        bus_start();
        write_byte(abyte, ack_n);
        check_eq({tag, "_nack"}, {31'h0, ack_n}, 32'h1);
        check_eq({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
        for (int i = 0; i < nextra; i++) begin
            write_byte(8'h00, ack_n);
            check_eq($sformatf("%s_ign%0d", tag, i), {31'h0, ack_n}, 32'h1);
        end
        bus_stop();
        wait_q();
        check_eq({tag, "_no_wr_done"}, wr_done_cnt - done0, 0);
        $display("txn %s: address byte 0x%02h ignored", tag, abyte);
    endtask

    // rib writes reg1 in exactly the clk the I2C write of 0x77 commits
    task automatic txn_collide();
        logic       ack_n;
        logic [7:0] d = 8'h77;
        int         done0 = wr_done_cnt;
        bus_start();
        write_byte(8'h90, ack_n);
        write_byte(8'h01, ack_n);
        for (int i = 7; i >= 1; i--) send_bit(d[i]);
        m_sda_low = ~d[0]; wait_q();
        scl = 1'b1;                      // sampled after SYNC_STAGES flops, acted on next clk
        @(negedge clk);
        @(negedge clk);
        addr_i = 32'h4; data_i = 32'h55; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0;
        repeat (2 * Q - 3) @(negedge clk);
        scl = 1'b0; wait_q();
        recv_bit(ack_n);
        check_eq("collide_ack", {31'h0, ack_n}, 32'h0);
        bus_stop();
        wait_q();
        m_regs[1] = 8'h55;
        m_ptr = 2'd2;
        check_eq("collide_wr_done", wr_done_cnt - done0, 1);
        $display("txn collide: rib 0x55 vs i2c 0x77 on reg1");
    endtask

    initial begin
        logic [7:0]  bq[$];
        logic [31:0] d;
        logic        ack_n;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'h0, busy_o}, 32'h0);
        check_eq("rst_wr_done", {31'h0, wr_done_o}, 32'h0);
        check_eq("rst_sda", {31'h0, sda}, 32'h1);
        check_all("rst");
        rst_n = 1'b1;
        wait_q();

        txn_read("rd_reset", 2, 1'b0, 8'h00);
        check_all("rd_reset");

        bq = {8'h02, 8'hA5, 8'h3C};
        txn_write("wr_ptr2", bq);
        check_all("wr_ptr2");

        txn_bad("bad_92", 8'h92, 2);
        check_all("bad_92");

        txn_read("wr_rd_wrap", 2, 1'b1, 8'h03);
        check_all("wr_rd_wrap");

        txn_collide();
        check_all("collide");

        // reset while the target is pulling sda low for a 0 data bit
        rib_write(32'h0, 8'h0F);
        m_regs[0] = 8'h0F;
        bq = {8'h00};
        txn_write("set_ptr0", bq);
        bus_start();
        write_byte(8'h91, ack_n);
        check_eq("mid_rd_ack", {31'h0, ack_n}, 32'h0);
        check_eq("mid_rd_sda_low", {31'h0, sda}, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rd_rst_sda", {31'h0, sda}, 32'h1);
        check_eq("mid_rd_rst_busy", {31'h0, busy_o}, 32'h0);
        model_reset();
        check_all("mid_rd_rst");
        m_sda_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        rst_n = 1'b1;
        wait_q();
        $display("txn mid_rd_rst: reset asserted during read");
        txn_read("post_rst", 1, 1'b0, 8'h00);

        // randomised traffic
        for (int t = 0; t < 24; t++) begin
            int kind = $urandom_range(0, 4);
            string tag = $sformatf("rnd%0d", t);
            case (kind)
                0: begin
                    int n = $urandom_range(0, 4);
                    bq = {};
                    bq.push_back(8'($urandom));
                    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
                    txn_write(tag, bq);
                end
                1: txn_read(tag, $urandom_range(1, 4), 1'b0, 8'h00);
                2: txn_read(tag, $urandom_range(1, 3), 1'b1, 8'($urandom));
                3: begin
                    logic [6:0] a;
                    do a = 7'($urandom); while (a == 7'h48);
                    txn_bad(tag, {a, 1'($urandom)}, $urandom_range(0, 1));
                end
                default: begin
                    logic [1:0] idx = 2'($urandom);
                    logic [7:0] v = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        rib_write(32'h10, v);
                        $display("txn %s: rib write to status ignored", tag);
                    end else begin
                        rib_write({28'h0, idx, 2'b00}, v);
                        m_regs[idx] = v;
                        $display("txn %s: rib write reg%0d=0x%02h", tag, idx, v);
                    end
                end
            endcase
            check_all(tag);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
